// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled serial receiver with majority voting, configurable
// framing/parity, sticky error and break flags, and a show-ahead receive FIFO.
//
// Read handshake: rd_data carries the FIFO head whenever rd_valid=1. A cycle
// with rd_en=1 and rd_valid=1 consumes the head at the next clock edge.
// rd_en while rd_valid=0 is ignored. There is no backpressure on the serial
// side: a character arriving into a full FIFO with no pop in that cycle is
// dropped and flagged in overrun.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 19200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int SIM        = 0
) (
  input  logic                          clk_50m,
  input  logic                          rst_n,
  input  logic                          sin,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic                          break_det,
  output logic [2:0]                    o_dbg_state
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int BAUD_OS  = BAUD * OVERSAMPLE;
  localparam int DIV_CALC = (CLK_HZ + BAUD_OS / 2) / BAUD_OS;
  localparam int DIV      = (SIM != 0) ? 4 : ((DIV_CALC < 1) ? 1 : DIV_CALC);
  localparam int DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW       = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [PW-1:0] PH_S0    = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_S1    = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_VOTE  = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BIT_LAST = 4'(DATA_BITS - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  // Elaboration-time guards on the parameter ranges the logic relies on.
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("OVERSAMPLE must be even and >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [1:0]             r_sync;
  logic                   r_sin_d;
  logic [DW-1:0]          r_div;
  logic [PW-1:0]          r_phase;
  logic                   r_s0, r_s1;
  logic [3:0]             r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_bit, r_par_bad;
  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [AW:0]            r_level;
  logic                   r_frame_err, r_parity_err, r_overrun, r_break_det;

  logic w_sin_s, w_fall, w_tick, w_active, w_vote_cyc, w_vote, w_par_exp, w_all_zero;
  logic w_start, w_shift, w_par_load, w_push_req, w_set_fe, w_set_pe, w_set_bk;
  logic w_pop, w_full, w_push, w_drop;

  assign w_sin_s    = r_sync[1];
  assign w_fall     = r_sin_d & ~w_sin_s;
  assign w_tick     = (r_div == DIV_LAST);
  assign w_active   = (r_state == S_START) || (r_state == S_DATA) ||
                      (r_state == S_PARITY) || (r_state == S_STOP);
  assign w_vote_cyc = w_tick & w_active & (r_phase == PH_VOTE);
  // Third sample is taken live on the vote cycle, so the vote needs no extra flop.
  assign w_vote     = (r_s0 & r_s1) | (r_s0 & w_sin_s) | (r_s1 & w_sin_s);
  assign w_par_exp  = (PARITY == 1) ? ~(^r_shift) : (^r_shift);
  assign w_all_zero = (r_shift == '0) & ~r_par_bit;

  // Two-flop synchroniser plus a delayed copy for edge detection; idle-high preset.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_sin_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[0], sin};
      r_sin_d <= w_sin_s;
    end
  end

  // Free-running sample-tick divider.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) r_div <= '0;
    else if (w_tick) r_div <= '0;
    else r_div <= r_div + 1'b1;
  end

  // Phase within the current bit; restarts on start detect, wraps every bit.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_s0    <= 1'b1;
      r_s1    <= 1'b1;
    end else if (w_start) begin
      r_phase <= '0;
    end else if (w_tick && w_active) begin
      if (r_phase == PH_S0) r_s0 <= w_sin_s;
      if (r_phase == PH_S1) r_s1 <= w_sin_s;
      r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
    end
  end

  // Character datapath: bit counter, LSB-first shift register, parity capture.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_par_bad <= 1'b0;
    end else if (w_start) begin
      r_bit_cnt <= '0;
      r_par_bit <= 1'b0;
      r_par_bad <= 1'b0;
    end else begin
      if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
      end
      if (w_par_load) begin
        r_par_bit <= w_vote;
        r_par_bad <= (w_vote != w_par_exp);
      end
    end
  end

  // Receiver FSM state register.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  end

  // Receiver FSM next state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_par_load  = 1'b0;
    w_push_req  = 1'b0;
    w_set_fe    = 1'b0;
    w_set_pe    = 1'b0;
    w_set_bk    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_start     = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_vote_cyc) w_state_nxt = w_vote ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_vote_cyc) begin
          w_shift = 1'b1;
          if (r_bit_cnt == BIT_LAST) w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_vote_cyc) begin
          w_par_load  = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_vote_cyc) begin
          if (w_vote) begin
            w_push_req  = 1'b1;
            w_set_pe    = r_par_bad;
            w_state_nxt = S_IDLE;
          end else if (w_all_zero) begin
            w_set_bk    = 1'b1;
            w_state_nxt = S_BREAK;
          end else begin
            w_set_fe    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        if (w_sin_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_pop  = rd_en & rd_valid;
  assign w_full = (r_level == LVL_FULL);
  assign w_push = w_push_req & (~w_full | w_pop);
  assign w_drop = w_push_req & w_full & ~w_pop;

  // FIFO storage; contents need no reset because rd_data is masked by rd_valid.
  always_ff @(posedge clk_50m) begin
    if (w_push) r_mem[r_wptr] <= r_shift;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave level unchanged.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky error flags; a set event outranks clr_err in the same cycle.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_break_det  <= 1'b0;
    end else begin
      r_frame_err  <= w_set_fe | (r_frame_err  & ~clr_err);
      r_parity_err <= w_set_pe | (r_parity_err & ~clr_err);
      r_overrun    <= w_drop   | (r_overrun    & ~clr_err);
      r_break_det  <= w_set_bk | (r_break_det  & ~clr_err);
    end
  end

  assign rd_valid    = (r_level != '0);
  assign rd_data     = rd_valid ? r_mem[r_rptr] : '0;
  assign level       = r_level;
  assign frame_err   = r_frame_err;
  assign parity_err  = r_parity_err;
  assign overrun     = r_overrun;
  assign break_det   = r_break_det;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: instance A is 8N1 with a 16-deep FIFO, instance B is
// 8E1 with a 4-deep FIFO. Both run with SIM=1, so one bit lasts 64 clocks.
module tb_uart_rx_fifo;

  localparam int BIT_CLKS = 64;
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sin_a, rd_en_a, clr_a, sin_b, rd_en_b, clr_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic       rd_valid_a, rd_valid_b;
  logic [4:0] level_a;
  logic [2:0] level_b;
  logic       fe_a, pe_a, ov_a, bk_a, fe_b, pe_b, ov_b, bk_b;
  logic [2:0] st_a, st_b;

  int n_checks = 0;
  int n_fail   = 0;
  int last_chg;

  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  logic [3:0] exp_flags [2];   // {frame, parity, overrun, break}

  uart_rx_fifo #(.SIM(1), .PARITY(0), .FIFO_DEPTH(16)) u_dut_a (
    .clk_50m(clk), .rst_n(rst_n), .sin(sin_a), .rd_en(rd_en_a), .clr_err(clr_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .level(level_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .break_det(bk_a),
    .o_dbg_state(st_a)
  );

  uart_rx_fifo #(.SIM(1), .PARITY(2), .FIFO_DEPTH(4)) u_dut_b (
    .clk_50m(clk), .rst_n(rst_n), .sin(sin_b), .rd_en(rd_en_b), .clr_err(clr_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .level(level_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b), .break_det(bk_b),
    .o_dbg_state(st_b)
  );

  // Watchdog: the run must end on its own even if the DUT wedges.
  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of test, want end within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic set_sin(input int which, input logic v);
    if (which == 0) sin_a = v; else sin_b = v;
  endtask

  task automatic drive_bit(input int which, input logic v);
    set_sin(which, v);
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  function automatic int lvl(input int which);
    return (which == 0) ? int'(level_a) : int'(level_b);
  endfunction

  function automatic logic [3:0] flags_of(input int which);
    return (which == 0) ? {fe_a, pe_a, ov_a, bk_a} : {fe_b, pe_b, ov_b, bk_b};
  endfunction

  // Reference model: outcome of one received frame from the framing rules.
  task automatic model_frame(input int which, input logic [7:0] d, input logic pbit,
                             input logic stopv);
    int   depth = (which == 0) ? 16 : 4;
    int   pmode = (which == 0) ? 0 : 2;
    logic exp_p = (pmode == 1) ? ~(^d) : (^d);
    if (stopv) begin
      if (which == 0) begin
        if (exp_q_a.size() < depth) exp_q_a.push_back(d); else exp_flags[0][1] = 1'b1;
      end else begin
        if (exp_q_b.size() < depth) exp_q_b.push_back(d); else exp_flags[1][1] = 1'b1;
      end
      if (pmode != 0 && pbit !== exp_p) exp_flags[which][2] = 1'b1;
    end else if (d == 8'h00 && (pmode == 0 || pbit == 1'b0)) begin
      exp_flags[which][0] = 1'b1;
    end else begin
      exp_flags[which][3] = 1'b1;
    end
  endtask

  // Send start, 8 data bits LSB first, optional parity, one stop bit.
  // Records in last_chg the cycle within the stop bit where level first moved.
  task automatic send_frame(input int which, input logic [7:0] d, input logic pbit,
                            input logic stopv);
    int base;
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (which == 1) drive_bit(which, pbit);
    set_sin(which, stopv);
    base     = lvl(which);
    last_chg = -1;
    for (int c = 0; c < BIT_CLKS; c++) begin
      @(negedge clk);
      if (last_chg < 0 && lvl(which) != base) last_chg = c;
    end
    set_sin(which, 1'b1);
    model_frame(which, d, pbit, stopv);
  endtask

  task automatic pop_one(input int which, output logic v, output logic [7:0] d);
    if (which == 0) begin v = rd_valid_a; d = rd_data_a; rd_en_a = 1'b1; end
    else begin v = rd_valid_b; d = rd_data_b; rd_en_b = 1'b1; end
    @(negedge clk);
    rd_en_a = 1'b0;
    rd_en_b = 1'b0;
  endtask

  task automatic pulse_clr(input int which);
    if (which == 0) clr_a = 1'b1; else clr_b = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    clr_b = 1'b0;
    exp_flags[which] = 4'b0000;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    sin_a = 1'b1; sin_b = 1'b1;
    rd_en_a = 1'b0; rd_en_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    exp_flags[0] = 4'b0000; exp_flags[1] = 4'b0000;
    repeat (4) @(negedge clk);
    n_checks++; if ({rd_valid_a, level_a, rd_data_a} !== 14'd0) begin n_fail++;
      $display("FAIL reset_fifo_a: got valid=%b level=%0d data=%h want 0", rd_valid_a, level_a, rd_data_a); end
    n_checks++; if ({rd_valid_b, level_b, rd_data_b} !== 12'd0) begin n_fail++;
      $display("FAIL reset_fifo_b: got valid=%b level=%0d data=%h want 0", rd_valid_b, level_b, rd_data_b); end
    n_checks++; if ({flags_of(0), flags_of(1)} !== 8'h00) begin n_fail++;
      $display("FAIL reset_flags: got %b_%b want 0", flags_of(0), flags_of(1)); end
    n_checks++; if (st_a !== ST_IDLE || st_b !== ST_IDLE) begin n_fail++;
      $display("FAIL reset_state: got %0d/%0d want %0d", st_a, st_b, ST_IDLE); end
    rst_n = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    n_checks++; if (st_a !== ST_IDLE || level_a !== 5'd0) begin n_fail++;
      $display("FAIL reset_after_release: got state=%0d level=%0d want idle/0", st_a, level_a); end
  endtask

  task automatic test_single();
    logic v; logic [7:0] d; logic [7:0] e;
    send_frame(0, 8'h49, 1'b0, 1'b1);
    n_checks++; if (last_chg < 20 || last_chg > 60) begin n_fail++;
      $display("FAIL single_push_time: got cycle %0d of stop bit want 20..60", last_chg); end
    n_checks++; if (rd_valid_a !== 1'b1 || int'(level_a) !== exp_q_a.size()) begin n_fail++;
      $display("FAIL single_level: got valid=%b level=%0d want 1/%0d", rd_valid_a, level_a, exp_q_a.size()); end
    n_checks++; if (flags_of(0) !== exp_flags[0]) begin n_fail++;
      $display("FAIL single_flags: got %b want %b", flags_of(0), exp_flags[0]); end
    e = exp_q_a.pop_front();
    pop_one(0, v, d);
    n_checks++; if (v !== 1'b1 || d !== e) begin n_fail++;
      $display("FAIL single_data: got valid=%b data=%h want 1/%h", v, d, e); end
    n_checks++; if (rd_valid_a !== 1'b0 || level_a !== 5'd0) begin n_fail++;
      $display("FAIL single_empty: got valid=%b level=%0d want 0/0", rd_valid_a, level_a); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [6];
    logic v; logic [7:0] d; logic [7:0] e;
    msg = '{8'h49, 8'h73, 8'h68, 8'h62, 8'h65, 8'h6C};
    for (int i = 0; i < 6; i++) send_frame(0, msg[i], 1'b0, 1'b1);
    n_checks++; if (int'(level_a) !== 6 || int'(level_a) !== exp_q_a.size()) begin n_fail++;
      $display("FAIL b2b_level: got %0d want 6", level_a); end
    for (int i = 0; i < 6; i++) begin
      e = exp_q_a.pop_front();
      pop_one(0, v, d);
      n_checks++; if (v !== 1'b1 || d !== e || e !== msg[i]) begin n_fail++;
        $display("FAIL b2b_pop%0d: got valid=%b data=%h want 1/%h", i, v, d, msg[i]); end
    end
    n_checks++; if (rd_valid_a !== 1'b0 || level_a !== 5'd0) begin n_fail++;
      $display("FAIL b2b_empty: got valid=%b level=%0d want 0/0", rd_valid_a, level_a); end
  endtask

  task automatic test_glitch();
    set_sin(0, 1'b0);
    repeat (16) @(negedge clk);
    set_sin(0, 1'b1);
    repeat (2 * BIT_CLKS) @(negedge clk);
    n_checks++; if (level_a !== 5'd0 || rd_valid_a !== 1'b0) begin n_fail++;
      $display("FAIL glitch_push: got level=%0d want 0", level_a); end
    n_checks++; if (st_a !== ST_IDLE) begin n_fail++;
      $display("FAIL glitch_state: got %0d want %0d", st_a, ST_IDLE); end
    n_checks++; if (flags_of(0) !== 4'b0000) begin n_fail++;
      $display("FAIL glitch_flags: got %b want 0000", flags_of(0)); end
  endtask

  task automatic test_frame_err();
    send_frame(0, 8'h41, 1'b0, 1'b0);
    drive_bit(0, 1'b1);
    n_checks++; if (fe_a !== 1'b1 || flags_of(0) !== exp_flags[0]) begin n_fail++;
      $display("FAIL frame_err_set: got %b want %b", flags_of(0), exp_flags[0]); end
    n_checks++; if (int'(level_a) !== exp_q_a.size()) begin n_fail++;
      $display("FAIL frame_err_level: got %0d want %0d", level_a, exp_q_a.size()); end
    pulse_clr(0);
    n_checks++; if (flags_of(0) !== 4'b0000) begin n_fail++;
      $display("FAIL frame_err_clr: got %b want 0000", flags_of(0)); end
  endtask

  task automatic test_break();
    logic v; logic [7:0] d; logic [7:0] e;
    set_sin(0, 1'b0);
    repeat (20 * BIT_CLKS) @(negedge clk);
    model_frame(0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (bk_a !== 1'b1 || flags_of(0) !== exp_flags[0]) begin n_fail++;
      $display("FAIL break_set: got %b want %b", flags_of(0), exp_flags[0]); end
    n_checks++; if (level_a !== 5'd0) begin n_fail++;
      $display("FAIL break_level: got %0d want 0", level_a); end
    set_sin(0, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    n_checks++; if (st_a !== ST_IDLE) begin n_fail++;
      $display("FAIL break_exit: got state %0d want %0d", st_a, ST_IDLE); end
    send_frame(0, 8'h55, 1'b0, 1'b1);
    e = exp_q_a.pop_front();
    pop_one(0, v, d);
    n_checks++; if (v !== 1'b1 || d !== e) begin n_fail++;
      $display("FAIL break_next_char: got valid=%b data=%h want 1/%h", v, d, e); end
    pulse_clr(0);
    n_checks++; if (flags_of(0) !== 4'b0000) begin n_fail++;
      $display("FAIL break_clr: got %b want 0000", flags_of(0)); end
  endtask

  task automatic test_random();
    logic v; logic [7:0] d; logic [7:0] e; logic [7:0] r;
    for (int i = 0; i < 10; i++) begin
      r = 8'($urandom_range(0, 255));
      send_frame(0, r, 1'b0, 1'b1);
      n_checks++; if (int'(level_a) !== exp_q_a.size()) begin n_fail++;
        $display("FAIL rand_level%0d: got %0d want %0d", i, level_a, exp_q_a.size()); end
      if ($urandom_range(0, 1) == 1 && exp_q_a.size() > 0) begin
        e = exp_q_a.pop_front();
        pop_one(0, v, d);
        n_checks++; if (v !== 1'b1 || d !== e) begin n_fail++;
          $display("FAIL rand_pop%0d: got valid=%b data=%h want 1/%h", i, v, d, e); end
      end
    end
    while (exp_q_a.size() > 0) begin
      e = exp_q_a.pop_front();
      pop_one(0, v, d);
      n_checks++; if (v !== 1'b1 || d !== e) begin n_fail++;
        $display("FAIL rand_drain: got valid=%b data=%h want 1/%h", v, d, e); end
    end
    n_checks++; if (rd_valid_a !== 1'b0 || flags_of(0) !== exp_flags[0]) begin n_fail++;
      $display("FAIL rand_end: got valid=%b flags=%b want 0/%b", rd_valid_a, flags_of(0), exp_flags[0]); end
  endtask

  task automatic test_overrun();
    logic v; logic [7:0] d; logic [7:0] e; logic [7:0] r;
    for (int i = 0; i < 5; i++) begin
      r = 8'($urandom_range(0, 255));
      send_frame(1, r, ^r, 1'b1);
    end
    n_checks++; if (level_b !== 3'd4 || int'(level_b) !== exp_q_b.size()) begin n_fail++;
      $display("FAIL overrun_level: got %0d want 4", level_b); end
    n_checks++; if (ov_b !== 1'b1 || flags_of(1) !== exp_flags[1]) begin n_fail++;
      $display("FAIL overrun_flags: got %b want %b", flags_of(1), exp_flags[1]); end
    for (int i = 0; i < 4; i++) begin
      e = exp_q_b.pop_front();
      pop_one(1, v, d);
      n_checks++; if (v !== 1'b1 || d !== e) begin n_fail++;
        $display("FAIL overrun_pop%0d: got valid=%b data=%h want 1/%h", i, v, d, e); end
    end
    n_checks++; if (rd_valid_b !== 1'b0 || level_b !== 3'd0) begin n_fail++;
      $display("FAIL overrun_empty: got valid=%b level=%0d want 0/0", rd_valid_b, level_b); end
    pulse_clr(1);
    n_checks++; if (flags_of(1) !== 4'b0000) begin n_fail++;
      $display("FAIL overrun_clr: got %b want 0000", flags_of(1)); end
  endtask

  task automatic test_parity();
    logic v; logic [7:0] d; logic [7:0] e;
    send_frame(1, 8'h03, 1'b1, 1'b1);
    n_checks++; if (pe_b !== 1'b1 || flags_of(1) !== exp_flags[1]) begin n_fail++;
      $display("FAIL parity_set: got %b want %b", flags_of(1), exp_flags[1]); end
    n_checks++; if (level_b !== 3'd1) begin n_fail++;
      $display("FAIL parity_level: got %0d want 1", level_b); end
    e = exp_q_b.pop_front();
    pop_one(1, v, d);
    n_checks++; if (v !== 1'b1 || d !== e || e !== 8'h03) begin n_fail++;
      $display("FAIL parity_data: got valid=%b data=%h want 1/03", v, d); end
    pulse_clr(1);
    send_frame(1, 8'h07, 1'b1, 1'b1);
    n_checks++; if (flags_of(1) !== exp_flags[1] || pe_b !== 1'b0) begin n_fail++;
      $display("FAIL parity_good: got %b want %b", flags_of(1), exp_flags[1]); end
    e = exp_q_b.pop_front();
    pop_one(1, v, d);
    n_checks++; if (v !== 1'b1 || d !== e) begin n_fail++;
      $display("FAIL parity_good_data: got valid=%b data=%h want 1/%h", v, d, e); end
  endtask

  task automatic test_reset_midframe();
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    set_sin(0, 1'b0);
    repeat (4 * BIT_CLKS) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (level_a !== 5'd0 || st_a !== ST_IDLE) begin n_fail++;
      $display("FAIL midreset_in_reset: got level=%0d state=%0d want 0/idle", level_a, st_a); end
    set_sin(0, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q_a.delete(); exp_q_b.delete();
    exp_flags[0] = 4'b0000; exp_flags[1] = 4'b0000;
    repeat (12 * BIT_CLKS) @(negedge clk);
    n_checks++; if (level_a !== 5'd0 || rd_valid_a !== 1'b0 || flags_of(0) !== exp_flags[0]) begin n_fail++;
      $display("FAIL midreset_after: got level=%0d valid=%b flags=%b want 0/0/0000", level_a, rd_valid_a, flags_of(0)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_break();
    test_random();
    test_overrun();
    test_parity();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised serial receiver for the board top levels. It samples the asynchronous sin pin with oversampling and majority voting. Decoded characters are pushed into a show-ahead FIFO read by the core. It supersedes the fixed 19200-baud, 8N1, unbuffered input path and adds configurable framing, parity, error/break detection and buffering.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
BAUD, 19200, line rate in bits/s
OVERSAMPLE, 16, sample ticks per bit; even, >= 8
DATA_BITS, 8, data bits per character; 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2; only the first stop bit is checked
FIFO_DEPTH, 16, entries; power of two, >= 2
SIM, 0, 1 = divider forced to 4 clocks per sample tick for fast simulation

Ports:
clk_50m  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sin  in  1  asynchronous serial line, idle high
rd_en  in  1  pop head entry; ignored when rd_valid=0
clr_err  in  1  synchronous clear of sticky flags
rd_data  out  DATA_BITS  FIFO head, valid while rd_valid=1
rd_valid  out  1  FIFO not empty
level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
frame_err  out  1  sticky: stop bit sampled low
parity_err  out  1  sticky: parity mismatch
overrun  out  1  sticky: character dropped, FIFO full
break_det  out  1  sticky: break condition seen

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM IDLE; synchroniser flops and tick divider reset; synchroniser preset to 1. Reset mid-frame aborts the frame with nothing pushed.
- sin passes through a 2-flop synchroniser (2 cycles latency) before any use.
- Tick divider: DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), or 4 when SIM=1. One-cycle tick every DIV clocks. Divider free-runs; the phase counter restarts on start detect.
- Bit value = majority of 3 synchronised samples at ticks OS/2-1, OS/2, OS/2+1 of each bit period.
- FSM states:
  IDLE: on synchronised falling edge go to START and zero the phase.
  START: vote at mid-bit. If 1 (glitch), return to IDLE silently; else go to DATA.
  DATA: DATA_BITS votes, LSB first, shifted into a register. Then go to PARITY if PARITY!=0, else STOP.
  PARITY: vote compared against the XOR of data bits (even) or its inverse (odd).
  STOP: vote at mid-stop-bit.
    - If 1: push {data} and set parity_err on mismatch (character still pushed).
    - If 0 and data and parity bits all 0: set break_det, go to BREAK, no push.
    - Else: set frame_err, no push.
    - Return to IDLE immediately after the first stop bit; the second stop bit needs no wait.
  BREAK: wait for synchronised sin=1, then go to IDLE.
- Push happens on the mid-stop vote cycle; rd_valid/level update on the next edge.
- FIFO is show-ahead: rd_data = head combinationally from the registered read pointer.
  - Pop on rd_en & rd_valid.
  - Push and pop in the same cycle: both occur and level is unchanged. This is also true when full, so no overrun.
  - Push when full without pop: character dropped, overrun set.
- Sticky flags: clr_err clears them. If clr_err and a new set event occur in the same cycle, the set wins.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; level ranges 0..FIFO_DEPTH.

Test Plan:
- SIM=1 (bit = 64 clocks), 8N1, send 0x49 -> rd_valid=1 one clock after mid-stop sample; rd_data=0x49; level=1; no flags set.
- Send "Ishbel" back-to-back with no reads -> level=6. Six pops return 0x49,0x73,0x68,0x62,0x65,0x6C, then rd_valid=0 and level=0.
- 16-clock low glitch on idle sin (less than half a bit) -> no push, FSM back in IDLE, all flags 0.
- Send 0x41 with stop bit driven 0 -> frame_err=1, level unchanged. clr_err pulse -> frame_err=0.
- Hold sin low for 20 bit times -> break_det=1, nothing pushed. After sin returns high, a following 0x55 is received correctly.
- FIFO_DEPTH=4, send 5 characters with no reads -> level=4, overrun=1, pops return the first 4. PARITY=2, send 0x03 with parity bit 1 -> parity_err=1 and 0x03 is pushed.
